padded_fmap_writer: RTL and testbench

Takes a streamed output feature map (OFM) and writes it into the next layer's input buffer with configurable padding on all four sides. This is the generalised successor of the fixed-PE, symmetric-padding controller. It adds separate pad amounts for top, bottom, left and right, independent height and width, a configurable pad value, a base address, a valid/ready input handshake and completion/error reporting. It sits between the PE-array output stage and the IFM buffer write port.

---
 rtl/padded_fmap_writer_pkg.sv | 36 +++
 rtl/padded_fmap_pos_counter.sv | 69 ++++++
 rtl/padded_fmap_writer.sv | 157 +++++++++++++++
 tb/tb_padded_fmap_writer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padded_fmap_writer_pkg.sv
// Shared types for the padded feature-map writer and its read-side sibling.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, packed job configuration struct, default widths.
package padded_fmap_writer_pkg;

   localparam int DEF_PE        = 16;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DIM_W     = 8;
   localparam int DEF_PAD_W     = 2;
   localparam int DEF_ADDR_STEP = 4;

   // Padded dimensions are dim + two pads, so two extra bits cover any overflow.
   localparam int CNT_W = DEF_DIM_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] base;
      logic [DEF_DIM_W-1:0]  c;
      logic [DEF_DIM_W-1:0]  w;
      logic [DEF_DIM_W-1:0]  h;
      logic [DEF_PAD_W-1:0]  pad_top;
      logic [DEF_PAD_W-1:0]  pad_bot;
      logic [DEF_PAD_W-1:0]  pad_left;
      logic [DEF_PAD_W-1:0]  pad_right;
      logic [DEF_DATA_W-1:0] pad_value;
   } fmap_cfg_t;

endpackage

// File: rtl/padded_fmap_pos_counter.sv
// Nested position counters (cg innermost, then x, then y) over the padded map.
// Latency: last/is_pad are combinational from the current position; advance steps on the next edge.
// Backpressure: counters hold whenever advance is low.
// Ports: clear resets the position to origin; cg_num/pw/ph are the padded extents;
//        pad_top/pad_left/ofm_w/ofm_h locate the data window; last flags the final position.
module padded_fmap_pos_counter
   import padded_fmap_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   input  logic [CNT_W-1:0]     cg_num,
   input  logic [CNT_W-1:0]     pw,
   input  logic [CNT_W-1:0]     ph,
   input  logic [DEF_PAD_W-1:0] pad_top,
   input  logic [DEF_PAD_W-1:0] pad_left,
   input  logic [DEF_DIM_W-1:0] ofm_w,
   input  logic [DEF_DIM_W-1:0] ofm_h,
   output logic                 last,
   output logic                 is_pad
);

   logic [CNT_W-1:0] cg;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             cg_last;
   logic             x_last;
   logic             y_last;
   logic [CNT_W-1:0] top_end;
   logic [CNT_W-1:0] left_end;

   assign cg_last  = (cg == cg_num - CNT_W'(1));
   assign x_last   = (x == pw - CNT_W'(1));
   assign y_last   = (y == ph - CNT_W'(1));
   assign last     = cg_last && x_last && y_last;

   // First row / column past the data window.
   assign top_end  = CNT_W'(pad_top) + CNT_W'(ofm_h);
   assign left_end = CNT_W'(pad_left) + CNT_W'(ofm_w);

   assign is_pad = (y < CNT_W'(pad_top)) || (y >= top_end) ||
                   (x < CNT_W'(pad_left)) || (x >= left_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cg <= '0;
         x  <= '0;
         y  <= '0;
      end else if (clear) begin
         cg <= '0;
         x  <= '0;
         y  <= '0;
      end else if (advance) begin
         if (!cg_last) begin
            cg <= cg + CNT_W'(1);
         end else begin
            cg <= '0;
            if (!x_last) begin
               x <= x + CNT_W'(1);
            end else begin
               x <= '0;
               y <= y_last ? '0 : y + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/padded_fmap_writer.sv
// Writes a streamed OFM into the next IFM buffer, framing it with per-side padding.
// Latency: write strobe/address/data registered, 1 cycle after the accept or pad decision; 1 word/cycle.
// Backpressure: in_ready only at data positions; a missing in_valid stalls the walk, pad words never wait.
// Ports: start + cfg_* describe a job; in_valid/in_ready/in_data is the OFM stream;
//        wr_en/wr_addr/wr_data drive the buffer; busy/done/cfg_err report job status.
module padded_fmap_writer
   import padded_fmap_writer_pkg::*;
#(
   parameter int PE        = DEF_PE,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DIM_W     = DEF_DIM_W,
   parameter int PAD_W     = DEF_PAD_W,
   parameter int ADDR_STEP = DEF_ADDR_STEP
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    cfg_base_addr,
   input  logic [DIM_W-1:0]     cfg_ofm_c,
   input  logic [DIM_W-1:0]     cfg_ofm_w,
   input  logic [DIM_W-1:0]     cfg_ofm_h,
   input  logic [PAD_W-1:0]     cfg_pad_top,
   input  logic [PAD_W-1:0]     cfg_pad_bot,
   input  logic [PAD_W-1:0]     cfg_pad_left,
   input  logic [PAD_W-1:0]     cfg_pad_right,
   input  logic [DATA_W-1:0]    cfg_pad_value,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PE*DATA_W-1:0] in_data,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [PE*DATA_W-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   fsm_state_t           state;
   fmap_cfg_t            cfg_in;
   fmap_cfg_t            cfg_q;
   logic [CNT_W-1:0]     cg_num;
   logic [CNT_W-1:0]     pw;
   logic [CNT_W-1:0]     ph;
   logic [ADDR_W-1:0]    ptr;
   logic                 fin;
   logic                 pos_last;
   logic                 pos_pad;
   logic                 issue;
   logic                 cfg_bad;
   logic [PE*DATA_W-1:0] pad_word;

   assign cfg_in = '{base:      cfg_base_addr,
                     c:         cfg_ofm_c,
                     w:         cfg_ofm_w,
                     h:         cfg_ofm_h,
                     pad_top:   cfg_pad_top,
                     pad_bot:   cfg_pad_bot,
                     pad_left:  cfg_pad_left,
                     pad_right: cfg_pad_right,
                     pad_value: cfg_pad_value};

   assign cfg_bad = ((cfg_q.c % DEF_DIM_W'(PE)) != '0) || (cfg_q.c == '0) ||
                    (cfg_q.w == '0) || (cfg_q.h == '0);

   assign pad_word = {PE{cfg_q.pad_value}};

   // fin: the final word has been issued; RUN lingers one cycle so that done
   // lands in the cycle after the last write strobe, not alongside it.
   assign in_ready = (state == ST_RUN) && !fin && !pos_pad;
   assign issue    = (state == ST_RUN) && !fin && (pos_pad || in_valid);

   padded_fmap_pos_counter u_pos (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == ST_CHECK),
      .advance  (issue),
      .cg_num   (cg_num),
      .pw       (pw),
      .ph       (ph),
      .pad_top  (cfg_q.pad_top),
      .pad_left (cfg_q.pad_left),
      .ofm_w    (cfg_q.w),
      .ofm_h    (cfg_q.h),
      .last     (pos_last),
      .is_pad   (pos_pad)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cfg_q   <= '0;
         cg_num  <= '0;
         pw      <= '0;
         ph      <= '0;
         ptr     <= '0;
         fin     <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cfg_q   <= cfg_in;
                  cfg_err <= 1'b0;
                  busy    <= 1'b1;
                  fin     <= 1'b0;
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // Derived extents come from the latched copy, so later cfg changes are harmless.
               cg_num <= CNT_W'(cfg_q.c / DEF_DIM_W'(PE));
               pw     <= CNT_W'(cfg_q.w) + CNT_W'(cfg_q.pad_left) + CNT_W'(cfg_q.pad_right);
               ph     <= CNT_W'(cfg_q.h) + CNT_W'(cfg_q.pad_top) + CNT_W'(cfg_q.pad_bot);
               ptr    <= cfg_q.base;
               if (cfg_bad) begin
                  cfg_err <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (fin) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (issue) begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= pos_pad ? pad_word : in_data;
                  // Address wraps modulo 2^ADDR_W by plain overflow.
                  ptr     <= ptr + ADDR_W'(ADDR_STEP);
                  if (pos_last) fin <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_padded_fmap_writer.sv
// Scoreboard bench for padded_fmap_writer: a reference model expands each job into
// its expected write list, a negedge monitor compares every write strobe against it.
module tb_padded_fmap_writer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  cfg_base_addr = '0;
   logic [7:0]   cfg_ofm_c = '0;
   logic [7:0]   cfg_ofm_w = '0;
   logic [7:0]   cfg_ofm_h = '0;
   logic [1:0]   cfg_pad_top = '0;
   logic [1:0]   cfg_pad_bot = '0;
   logic [1:0]   cfg_pad_left = '0;
   logic [1:0]   cfg_pad_right = '0;
   logic [7:0]   cfg_pad_value = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         wr_en;
   logic [15:0]  wr_addr;
   logic [127:0] wr_data;
   logic         busy;
   logic         done;
   logic         cfg_err;

   padded_fmap_writer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_ofm_c     (cfg_ofm_c),
      .cfg_ofm_w     (cfg_ofm_w),
      .cfg_ofm_h     (cfg_ofm_h),
      .cfg_pad_top   (cfg_pad_top),
      .cfg_pad_bot   (cfg_pad_bot),
      .cfg_pad_left  (cfg_pad_left),
      .cfg_pad_right (cfg_pad_right),
      .cfg_pad_value (cfg_pad_value),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]  addr;
      logic [127:0] data;
      bit           is_data;
   } exp_t;

   exp_t         exp_q[$];
   int           acc_q[$];
   logic [127:0] drv_q[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int nwr = 0;
   int first_wr = 0;
   int last_wr = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   bit busy_at_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write must match the head of the expected queue; data words must
   // appear exactly one cycle after their handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", wr_en, 1'b0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wr_addr", wr_addr, e.addr);
               check("wr_data", wr_data, e.data);
               if (e.is_data) begin
                  if (acc_q.size() == 0) check("data_write_without_accept", wr_en, 1'b0);
                  else check("data_latency", cyc - acc_q.pop_front(), 1);
               end
            end
            if (nwr == 0) first_wr = cyc;
            last_wr = cyc;
            nwr++;
         end
         if (done) begin
            done_cyc     = cyc;
            busy_at_done = busy;
            done_cnt++;
         end
      end
   end

   // vmode 0: in_valid high except for a stall of stall_len ready cycles before data word
   // stall_at; vmode 1: random in_valid. abort_after > 0 leaves the job after that many writes.
   task automatic run_job(input logic [15:0] base, input int c, input int w, input int h,
                          input int t, input int b, input int l, input int r,
                          input logic [7:0] pv, input int vmode, input int stall_at,
                          input int stall_len, input int abort_after, input bit second_start);
      logic [127:0] words[$];
      exp_t         e;
      bit           err;
      bit           pad;
      int           cgn, pw, ph, k, di, d, d0, s_cyc, stall_rem, nexp;
      err  = (c % 16 != 0) || (c == 0) || (w == 0) || (h == 0);
      nexp = 0;
      if (!err) begin
         cgn = c / 16;
         pw  = w + l + r;
         ph  = h + t + b;
         for (int i = 0; i < cgn * w * h; i++)
            words.push_back({$urandom, $urandom, $urandom, $urandom});
         k  = 0;
         di = 0;
         for (int y = 0; y < ph; y++)
            for (int x = 0; x < pw; x++)
               for (int g = 0; g < cgn; g++) begin
                  pad       = (y < t) || (y >= t + h) || (x < l) || (x >= l + w);
                  e.addr    = base + 16'(k * 4);
                  e.is_data = !pad;
                  if (pad) e.data = {16{pv}};
                  else begin
                     e.data = words[di];
                     di++;
                  end
                  exp_q.push_back(e);
                  k++;
               end
         nexp = k;
      end
      drv_q     = words;
      d         = 0;
      stall_rem = stall_len;
      nwr       = 0;
      d0        = done_cnt;

      @(negedge clk);
      cfg_base_addr = base;
      cfg_ofm_c     = 8'(c);
      cfg_ofm_w     = 8'(w);
      cfg_ofm_h     = 8'(h);
      cfg_pad_top   = 2'(t);
      cfg_pad_bot   = 2'(b);
      cfg_pad_left  = 2'(l);
      cfg_pad_right = 2'(r);
      cfg_pad_value = pv;
      start         = 1'b1;
      s_cyc         = cyc;

      for (int n = 1; n < 4000 && done_cnt == d0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            check("busy_after_start", busy, 1'b1);
         end
         if (second_start && n == 4) begin
            start         = 1'b1;
            cfg_base_addr = base ^ 16'h0100;
            cfg_pad_value = ~pv;
         end
         if (second_start && n == 5) begin
            start         = 1'b0;
            cfg_base_addr = base;
            cfg_pad_value = pv;
         end
         if (abort_after > 0 && nwr >= abort_after) break;
         if (drv_q.size() == 0) begin
            in_valid = 1'b0;
         end else begin
            if (d == stall_at && stall_rem > 0) begin
               in_valid = 1'b0;
               if (in_ready) stall_rem--;
            end else if (vmode == 1) begin
               in_valid = ($urandom_range(0, 3) != 0);
            end else begin
               in_valid = 1'b1;
            end
            in_data = drv_q[0];
            if (in_valid && in_ready) begin
               void'(drv_q.pop_front());
               acc_q.push_back(cyc);
               d++;
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;

      if (abort_after == 0) begin
         check("done_seen", done_cnt - d0, 1);
         repeat (2) @(negedge clk);
         check("writes_left", exp_q.size(), 0);
         check("words_left", drv_q.size(), 0);
         check("cfg_err", cfg_err, err);
         check("busy_at_done", busy_at_done, 1'b0);
         if (err) begin
            check("err_done_latency", done_cyc - s_cyc, 2);
            check("err_write_count", nwr, 0);
         end else begin
            check("done_after_last_write", done_cyc - last_wr, 1);
            check("write_count", nwr, nexp);
            if (vmode == 0) check("idle_write_cycles", last_wr - first_wr + 1 - nwr, stall_len);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, wr_en, 1'b0);
      check({tag, "_wr_addr"}, wr_addr, 16'h0);
      check({tag, "_wr_data"}, wr_data, 128'h0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_cfg_err"}, cfg_err, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b0);
   endtask

   initial begin
      logic [7:0] pv;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 4-side pad of 1 around a 2x2x32 map: 32 writes, first data at address 40.
      pv = 8'($urandom);
      run_job(16'h0000, 32, 2, 2, 1, 1, 1, 1, pv, 0, -1, 0, 0, 1'b0);
      // No padding: straight pass-through.
      run_job(16'h0000, 16, 4, 2, 0, 0, 0, 0, 8'h00, 0, -1, 0, 0, 1'b0);
      // Input stall of 3 ready cycles at the second data word.
      run_job(16'h0000, 32, 2, 2, 1, 1, 1, 1, pv, 0, 1, 3, 0, 1'b0);
      // Asymmetric pads with address wrap through 0xFFFF.
      run_job(16'hFFF8, 16, 3, 2, 0, 2, 0, 1, 8'h80, 0, -1, 0, 0, 1'b0);
      // Illegal channel count, then a zero width.
      run_job(16'h0040, 24, 2, 2, 1, 1, 1, 1, 8'h11, 0, -1, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("cfg_err_sticky", cfg_err, 1'b1);
      run_job(16'h0040, 16, 0, 2, 0, 0, 0, 0, 8'h11, 0, -1, 0, 0, 1'b0);
      // A second start while busy must not disturb the running job.
      run_job(16'h1230, 32, 3, 2, 2, 1, 0, 3, 8'h5A, 1, -1, 0, 0, 1'b1);

      for (int j = 0; j < 4; j++)
         run_job(16'($urandom), 16 * $urandom_range(1, 3), $urandom_range(1, 4),
                 $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom), 1, -1, 0, 0, 1'b0);

      // Reset in the middle of RUN, then replay the same job from scratch.
      pv = 8'($urandom);
      run_job(16'h0200, 32, 2, 2, 1, 1, 1, 1, pv, 0, -1, 0, 12, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("midrun_reset");
      exp_q.delete();
      acc_q.delete();
      drv_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_job(16'h0200, 32, 2, 2, 1, 1, 1, 1, pv, 0, -1, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
